// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, instruction width and the
// NOP word presented on the inst bus when no instruction is executing.
package cpu_pkg;

   localparam int INST_W = 16;

   // op1=10, op2=001: decodes with every write, memory, branch and halt control low
   localparam logic [INST_W-1:0] NOP_INST = 16'h8800;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_HALT
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: owns the PC, reads synchronous instruction
// memory and presents one instruction per EXEC phase to the decoder.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              stall,
   input  logic              jump,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] target,
   input  logic              hlt,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              retire
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc = pc_q + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            inst_d  = imem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // a stalled EXEC holds everything and ignores control inputs
            if (!stall) begin
               if (hlt) begin
                  state_d = S_HALT;
               end else if (jump || branch_taken) begin
                  pc_d    = target;
                  state_d = S_FETCH;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
         end
         S_HALT: begin
            if (run) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst_valid = (state_q == S_EXEC);
   assign halted     = (state_q == S_HALT);
   assign inst       = inst_valid ? inst_q : NOP_INST;
   assign retire     = inst_valid && !stall;

endmodule
